// File: rtl/shift_register_out_pkg.sv
// rtl/shift_register_out_pkg.sv - shared definitions for the serial link transmitter and receiver
// Purpose: FSM state encodings, frame length helper and default line levels
//          used by both ends of the serial link.
// Ports:   none (package).
package shift_register_out_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam logic START_BIT_DEF  = 1'b1;
  localparam logic STOP_BIT_DEF   = 1'b0;
  localparam logic IDLE_LEVEL_DEF = 1'b0;

  // One start bit, the payload, one stop bit.
  function automatic int frame_len(input int data_w);
    return data_w + 2;
  endfunction

endpackage

// File: rtl/frame_bit_counter.sv
// rtl/frame_bit_counter.sv - frame bit position counter with last-bit flag
// Purpose: counts the frame bit currently on the line; clear restarts at 0,
//          enable advances by one, no wrap-around logic is needed because the
//          FSM leaves SHIFT on the last bit.
// Ports:
//   clk      in   clock
//   reset_n  in   async active-low reset
//   clear    in   restart count at 0 (takes priority over enable)
//   enable   in   advance count
//   last     out  count is on the final frame bit (FRAME_LEN-1)
module frame_bit_counter #(
  parameter int CNT_W     = 4,
  parameter int FRAME_LEN = 10
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic last
);

  logic [CNT_W-1:0] value;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      value <= '0;
    end else if (clear) begin
      value <= '0;
    end else if (enable) begin
      value <= value + 1'b1;
    end
  end

  assign last = (value == CNT_W'(FRAME_LEN - 1));

endmodule

// File: rtl/shift_register_out.sv
// rtl/shift_register_out.sv - parallel-in/serial-out frame transmitter
// Purpose: accepts a DATA_W-bit word on a valid/ready handshake and sends
//          start bit, data MSB first, stop bit on sout, one bit per clock,
//          then pulses pout for one cycle so the receiver presents its word.
// Ports:
//   clk         in   clock
//   reset_n     in   async active-low reset
//   load_data   in   word to send, sampled on accept
//   load_valid  in   producer has a word
//   load_ready  out  word can be accepted this cycle (IDLE or DONE)
//   sout        out  registered serial line
//   pout        out  registered one-cycle frame-complete strobe
//   busy        out  frame in flight (state is not IDLE)
module shift_register_out
  import shift_register_out_pkg::*;
#(
  parameter int   DATA_W     = 8,
  parameter logic START_BIT  = START_BIT_DEF,
  parameter logic STOP_BIT   = STOP_BIT_DEF,
  parameter logic IDLE_LEVEL = IDLE_LEVEL_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_valid,
  output logic              load_ready,
  output logic              sout,
  output logic              pout,
  output logic              busy
);

  localparam int FRAME_LEN = frame_len(DATA_W);
  localparam int CNT_W     = $clog2(FRAME_LEN);

  state_t               state;
  logic [FRAME_LEN-1:0] shreg;
  logic                 cnt_last;
  logic                 accept;

  // Gated by reset_n so the producer never sees ready while held in reset.
  assign load_ready = reset_n & ((state == ST_IDLE) | (state == ST_DONE));
  assign accept     = load_valid & load_ready;
  assign busy       = (state != ST_IDLE);

  frame_bit_counter #(
    .CNT_W    (CNT_W),
    .FRAME_LEN(FRAME_LEN)
  ) u_cnt (
    .clk    (clk),
    .reset_n(reset_n),
    .clear  (accept),
    .enable (state == ST_SHIFT),
    .last   (cnt_last)
  );

  // sout is loaded with the start bit on the accept edge itself, so the
  // shift register's MSB is always the bit already on the line and the next
  // bit to drive sits one position below it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
      shreg <= '0;
      sout  <= IDLE_LEVEL;
      pout  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          pout <= 1'b0;
          if (accept) begin
            state <= ST_SHIFT;
            shreg <= {START_BIT, load_data, STOP_BIT};
            sout  <= START_BIT;
          end
        end
        ST_SHIFT: begin
          if (cnt_last) begin
            state <= ST_DONE;
            sout  <= IDLE_LEVEL;
            pout  <= 1'b1;
          end else begin
            shreg <= {shreg[FRAME_LEN-2:0], 1'b0};
            sout  <= shreg[FRAME_LEN-2];
          end
        end
        ST_DONE: begin
          pout <= 1'b0;
          if (accept) begin
            state <= ST_SHIFT;
            shreg <= {START_BIT, load_data, STOP_BIT};
            sout  <= START_BIT;
          end else begin
            state <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
          sout  <= IDLE_LEVEL;
          pout  <= 1'b0;
        end
      endcase
    end
  end

endmodule
